// File: rtl/uart_pkg.sv
// Shared constants and state types for the uart_rx_tx core.
package uart_pkg;

    // Bit-period divisors for a 12 MHz system clock.
    localparam int B115200   = 104;
    localparam int B57600    = 208;
    localparam int B9600     = 1250;
    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_baudgen.sv
// Bit-period counter: pulses tick on the last cycle of a full or half period.
module uart_baudgen
    import uart_pkg::*;
#(
    parameter int BAUD = B115200
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic half,
    output logic tick
);

    localparam int CW = $clog2(BAUD);
    localparam logic [CW-1:0] FULL_LIM = CW'(BAUD - 1);
    localparam logic [CW-1:0] HALF_LIM = CW'(BAUD / 2 - 1);

    logic [CW-1:0] count;

    assign tick = (count == (half ? HALF_LIM : FULL_LIM));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            count <= '0;
        else if (clear || tick)
            count <= '0;
        else
            count <= count + CW'(1);
    end

endmodule

// File: rtl/uart_rx_tx.sv
// Full-duplex 8N1 UART with independent RX/TX FSMs sharing one bit period.
// Define UART_LOOPBACK_EN to feed the receiver from o_tx instead of i_rx.
module uart_rx_tx
    import uart_pkg::*;
#(
    parameter int BAUD = B115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_rx,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic [7:0] o_rx_data,
    output logic       o_rx_data_valid,
    output logic       o_tx,
    output logic       o_tx_ready
);

    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    tx_state_t      tx_state, tx_state_next;
    logic [7:0]     tx_shift, tx_shift_next;
    logic [IW-1:0]  tx_idx, tx_idx_next;
    logic           tx_line_next;
    logic           tx_tick;

    rx_state_t      rx_state, rx_state_next;
    logic [7:0]     rx_shift, rx_shift_next;
    logic [IW-1:0]  rx_idx, rx_idx_next;
    logic [7:0]     rx_data_next;
    logic           rx_valid_next;
    logic           rx_tick;
    logic           rx_in, rx_meta, rx_sync;

`ifdef UART_LOOPBACK_EN
    assign rx_in = o_tx;
`else
    assign rx_in = i_rx;
`endif

    uart_baudgen #(.BAUD(BAUD)) tx_baud (
        .clk   (clk),
        .rstn  (rstn),
        .clear (tx_state == TX_IDLE),
        .half  (1'b0),
        .tick  (tx_tick)
    );

    uart_baudgen #(.BAUD(BAUD)) rx_baud (
        .clk   (clk),
        .rstn  (rstn),
        .clear (rx_state == RX_IDLE),
        .half  (rx_state == RX_START),
        .tick  (rx_tick)
    );

    assign o_tx_ready = (tx_state == TX_IDLE);

    always_comb begin
        tx_state_next = tx_state;
        tx_shift_next = tx_shift;
        tx_idx_next   = tx_idx;
        unique case (tx_state)
            TX_IDLE: if (i_tx_start) begin
                tx_state_next = TX_START;
                tx_shift_next = i_tx_data;
            end
            TX_START: if (tx_tick) begin
                tx_state_next = TX_DATA;
                tx_idx_next   = '0;
            end
            TX_DATA: if (tx_tick) begin
                if (tx_idx == LAST_BIT)
                    tx_state_next = TX_STOP;
                else
                    tx_idx_next = tx_idx + IW'(1);
            end
            TX_STOP: if (tx_tick) tx_state_next = TX_IDLE;
            default: tx_state_next = TX_IDLE;
        endcase
        // The line level is chosen from the next state so o_tx can stay a plain flop.
        unique case (tx_state_next)
            TX_START: tx_line_next = 1'b0;
            TX_DATA:  tx_line_next = tx_shift_next[tx_idx_next];
            default:  tx_line_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state <= TX_IDLE;
            tx_shift <= '0;
            tx_idx   <= '0;
            o_tx     <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_shift <= tx_shift_next;
            tx_idx   <= tx_idx_next;
            o_tx     <= tx_line_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_shift_next = rx_shift;
        rx_idx_next   = rx_idx;
        rx_data_next  = o_rx_data;
        rx_valid_next = 1'b0;
        unique case (rx_state)
            RX_IDLE: if (!rx_sync) rx_state_next = RX_START;
            RX_START: if (rx_tick) begin
                rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
                rx_idx_next   = '0;
            end
            RX_DATA: if (rx_tick) begin
                rx_shift_next = {rx_sync, rx_shift[7:1]};
                if (rx_idx == LAST_BIT)
                    rx_state_next = RX_STOP;
                else
                    rx_idx_next = rx_idx + IW'(1);
            end
            RX_STOP: if (rx_tick) begin
                rx_state_next = RX_IDLE;
                if (rx_sync) begin
                    rx_data_next  = rx_shift;
                    rx_valid_next = 1'b1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta         <= 1'b1;
            rx_sync         <= 1'b1;
            rx_state        <= RX_IDLE;
            rx_shift        <= '0;
            rx_idx          <= '0;
            o_rx_data       <= 8'h00;
            o_rx_data_valid <= 1'b0;
        end else begin
            rx_meta         <= rx_in;
            rx_sync         <= rx_meta;
            rx_state        <= rx_state_next;
            rx_shift        <= rx_shift_next;
            rx_idx          <= rx_idx_next;
            o_rx_data       <= rx_data_next;
            o_rx_data_valid <= rx_valid_next;
        end
    end

endmodule

// File: tb/tb_uart_rx_tx.sv
// Directed bench for uart_rx_tx at a 16-cycle bit period.
module tb_uart_rx_tx;

    localparam int BAUD = 16;
    // Cycles after the first low-sampling edge T at which the valid pulse is visible.
    localparam int RX_PULSE = 2 + BAUD / 2 + 9 * BAUD;

    logic       clk;
    logic       rstn;
    logic       i_rx;
    logic       i_tx_start;
    logic [7:0] i_tx_data;
    logic [7:0] o_rx_data;
    logic       o_rx_data_valid;
    logic       o_tx;
    logic       o_tx_ready;

    int checks = 0;
    int errors = 0;
    int pulse_count = 0;
    logic [7:0] pulse_data = 8'h00;

    uart_rx_tx #(.BAUD(BAUD)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .i_rx            (i_rx),
        .i_tx_start      (i_tx_start),
        .i_tx_data       (i_tx_data),
        .o_rx_data       (o_rx_data),
        .o_rx_data_valid (o_rx_data_valid),
        .o_tx            (o_tx),
        .o_tx_ready      (o_tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_rx_data_valid === 1'b1) begin
            pulse_count++;
            pulse_data = o_rx_data;
        end
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the transmitter idle; returns at the negedge where ready is back.
    task automatic tx_frame(input logic [7:0] d, input bit inject);
        logic [9:0] frame;
        frame = {1'b1, d, 1'b0};
        i_tx_start = 1'b1;
        i_tx_data  = d;
        @(posedge clk);
        @(negedge clk);
        i_tx_start = 1'b0;
        i_tx_data  = ~d;
        for (int p = 0; p < 10 * BAUD; p++) begin
            check1("tx_line", o_tx, frame[p / BAUD]);
            check1("tx_busy", o_tx_ready, 1'b0);
            if (inject && p == 40) begin
                i_tx_start = 1'b1;
                i_tx_data  = 8'h00;
            end else begin
                i_tx_start = 1'b0;
            end
            @(negedge clk);
        end
        check1("tx_ready_back", o_tx_ready, 1'b1);
        check1("tx_line_idle", o_tx, 1'b1);
    endtask

    // Drives one serial frame on i_rx starting at the current negedge.
    task automatic rx_frame(input logic [7:0] d, input logic stop_bit, input logic [7:0] exp_data);
        logic [9:0] frame;
        frame = {stop_bit, d, 1'b0};
        for (int q = -1; q < 11 * BAUD; q++) begin
            if ((q + 1) % BAUD == 0)
                i_rx = ((q + 1) / BAUD < 10) ? frame[(q + 1) / BAUD] : 1'b1;
            check1("rx_valid", o_rx_data_valid, (stop_bit == 1'b1) && (q == RX_PULSE));
            if (q == RX_PULSE)
                check8("rx_data_at_pulse", o_rx_data, exp_data);
            @(negedge clk);
        end
        check8("rx_data_held", o_rx_data, exp_data);
    endtask

    initial begin
        rstn       = 1'b0;
        i_rx       = 1'b1;
        i_tx_start = 1'b0;
        i_tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check1("rst_tx", o_tx, 1'b1);
        check1("rst_ready", o_tx_ready, 1'b1);
        check1("rst_valid", o_rx_data_valid, 1'b0);
        check8("rst_rx_data", o_rx_data, 8'h00);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check1("post_rst_tx", o_tx, 1'b1);
        check1("post_rst_ready", o_tx_ready, 1'b1);

        $display("[TB] transmit 0xA5 with a busy-time start, then 0x55 and 0x0F back to back");
        tx_frame(8'hA5, 1'b1);
        repeat (3) @(negedge clk);
        tx_frame(8'h55, 1'b0);
        tx_frame(8'h0F, 1'b0);
        repeat (4) @(negedge clk);

`ifdef UART_LOOPBACK_EN
        $display("[TB] loopback 0xC3");
        pulse_count = 0;
        tx_frame(8'hC3, 1'b0);
        repeat (20) @(negedge clk);
        check8("loop_pulse_count", 8'(pulse_count), 8'd1);
        check8("loop_data", pulse_data, 8'hC3);
        check8("loop_rx_data", o_rx_data, 8'hC3);
`else
        $display("[TB] receive 0x3C, framing error, glitch, 0x81");
        rx_frame(8'h3C, 1'b1, 8'h3C);
        repeat (5) @(negedge clk);
        rx_frame(8'hA7, 1'b0, 8'h3C);
        repeat (5) @(negedge clk);
        pulse_count = 0;
        i_rx = 1'b0;
        repeat (3) @(negedge clk);
        i_rx = 1'b1;
        repeat (60) @(negedge clk);
        check8("glitch_pulse_count", 8'(pulse_count), 8'd0);
        check8("glitch_rx_data", o_rx_data, 8'h3C);
        rx_frame(8'h81, 1'b1, 8'h81);
        repeat (5) @(negedge clk);
`endif

        $display("[TB] reset in the middle of a TX and RX frame");
        pulse_count = 0;
        i_tx_start  = 1'b1;
        i_tx_data   = 8'h00;
        i_rx        = 1'b0;
        @(negedge clk);
        i_tx_start  = 1'b0;
        repeat (39) @(negedge clk);
        check1("pre_abort_tx", o_tx, 1'b0);
        check1("pre_abort_ready", o_tx_ready, 1'b0);
        rstn = 1'b0;
        #1;
        check1("abort_tx", o_tx, 1'b1);
        check1("abort_ready", o_tx_ready, 1'b1);
        check1("abort_valid", o_rx_data_valid, 1'b0);
        check8("abort_rx_data", o_rx_data, 8'h00);
        i_rx = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 12 * BAUD; c++) begin
            check1("after_abort_tx", o_tx, 1'b1);
            @(negedge clk);
        end
        check8("after_abort_pulses", 8'(pulse_count), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
